// File: rtl/ps2_keyb_fifo.sv
// ---------------------------------------------------------------------------
// ps2_keyb_fifo
//
// Byte FIFO between the PS/2 keyboard controller and the CPU. Scan codes
// arrive as one-cycle strobes on the push port. The CPU drains them through
// a small Wishbone slave with status, control and an optional level
// interrupt.
//
// Ports:
//   wb_clk_i   system clock (single clock domain)
//   rst_       asynchronous active-low reset
//   kb_dat_i   scan-code byte from the keyboard controller
//   kb_stb_i   one-cycle strobe qualifying kb_dat_i
//   wb_adr_i   register select: 0 DATA, 1 STATUS/CTRL, 2 COUNT, 3 reserved
//   wb_dat_i   write data
//   wb_dat_o   registered read data, held until the next read ack
//   wb_we_i    write enable
//   wb_stb_i   strobe
//   wb_cyc_i   cycle
//   wb_ack_o   registered acknowledge, one cycle per request
//   irq_o      registered level interrupt (ie & not-empty)
//
// Parameters:
//   DEPTH_LOG2 FIFO depth is 2**DEPTH_LOG2 bytes (1..7)
//
// Build option:
//   PS2_KEYB_FIFO_IRQ_EN  when defined, the interrupt enable flop and irq_o
//                         are present. When undefined, irq_o is tied low and
//                         the STATUS ie bit reads 0.
// ---------------------------------------------------------------------------
module ps2_keyb_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       wb_clk_i,
    input  logic       rst_,
    input  logic [7:0] kb_dat_i,
    input  logic       kb_stb_i,
    input  logic [1:0] wb_adr_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    input  logic       wb_we_i,
    input  logic       wb_stb_i,
    input  logic       wb_cyc_i,
    output logic       wb_ack_o,
    output logic       irq_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    localparam logic [CW-1:0]         DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    localparam logic [1:0] ADR_DATA  = 2'd0;
    localparam logic [1:0] ADR_CTRL  = 2'd1;
    localparam logic [1:0] ADR_COUNT = 2'd2;

    // Storage (no reset: contents are don't-care after reset)
    logic [7:0] mem [DEPTH];

    // State
    logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]         count_reg, count_next;
    logic                  ovf_reg, ovf_next;
    logic                  ack_reg, ack_next;
    logic [7:0]            dat_reg, dat_next;

    // Decoded bus request; a request takes effect on the edge that
    // registers its ack, so it is qualified by !ack_reg.
    logic req, rd_req, wr_req, ctrl_wr;
    logic flush, clr_ovf;
    logic full, nempty;
    logic pop, push, overflow;
    logic ie_bit;
    logic [7:0] status_byte;
    logic [7:0] rd_data;

    assign req     = wb_cyc_i & wb_stb_i & ~ack_reg;
    assign rd_req  = req & ~wb_we_i;
    assign wr_req  = req & wb_we_i;
    assign ctrl_wr = wr_req & (wb_adr_i == ADR_CTRL);
    assign flush   = ctrl_wr & wb_dat_i[1];
    assign clr_ovf = ctrl_wr & wb_dat_i[7];

    assign full   = (count_reg == DEPTH_CNT);
    assign nempty = (count_reg != '0);

    assign pop = rd_req & (wb_adr_i == ADR_DATA) & nempty;

    // A pop in the same cycle frees the slot, so a full FIFO can still
    // accept a byte. Flush overrides any push in its cycle.
    assign push     = kb_stb_i & (~full | pop) & ~flush;
    assign overflow = kb_stb_i & full & ~pop;

    assign status_byte = {ovf_reg, full, nempty, ie_bit, 4'b0000};

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            rd_ptr_next = wr_ptr_reg;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_ONE;
                2'b01:   count_next = count_reg - CNT_ONE;
                default: count_next = count_reg;
            endcase
        end
    end

    // An overflow in the same cycle as a clear leaves ovf set.
    assign ovf_next = (ovf_reg & ~clr_ovf) | overflow;

    assign ack_next = wb_cyc_i & wb_stb_i & ~ack_reg;

    always_comb begin
        rd_data = 8'h00;
        case (wb_adr_i)
            ADR_DATA:  rd_data = pop ? mem[rd_ptr_reg] : 8'h00;
            ADR_CTRL:  rd_data = status_byte;
            ADR_COUNT: rd_data = 8'(count_reg);
            default:   rd_data = 8'h00;
        endcase
    end

    // Read data only changes on a read ack and holds otherwise.
    assign dat_next = rd_req ? rd_data : dat_reg;

    always_ff @(posedge wb_clk_i or negedge rst_) begin
        if (!rst_) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
            ack_reg    <= 1'b0;
            dat_reg    <= 8'h00;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            ovf_reg    <= ovf_next;
            ack_reg    <= ack_next;
            dat_reg    <= dat_next;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wr_ptr_reg] <= kb_dat_i;
        end
    end

    assign wb_ack_o = ack_reg;
    assign wb_dat_o = dat_reg;

`ifdef PS2_KEYB_FIFO_IRQ_EN
    logic ie_reg, ie_next;
    logic irq_reg;
    logic unused_wdat;

    assign ie_next = ctrl_wr ? wb_dat_i[0] : ie_reg;

    // irq follows the registered state, so it trails a push/pop/flush or
    // an ie write by one cycle.
    always_ff @(posedge wb_clk_i or negedge rst_) begin
        if (!rst_) begin
            ie_reg  <= 1'b0;
            irq_reg <= 1'b0;
        end else begin
            ie_reg  <= ie_next;
            irq_reg <= ie_reg & nempty;
        end
    end

    assign ie_bit      = ie_reg;
    assign irq_o       = irq_reg;
    assign unused_wdat = ^wb_dat_i[6:2];
`else
    logic unused_wdat;

    assign ie_bit      = 1'b0;
    assign irq_o       = 1'b0;
    assign unused_wdat = ^{wb_dat_i[6:2], wb_dat_i[0]};
`endif

endmodule

// File: tb/tb_ps2_keyb_fifo.sv
// ---------------------------------------------------------------------------
// Testbench for ps2_keyb_fifo (DEPTH_LOG2 = 2, depth 4).
// Directed vector table, randomized traffic against a queue-based model,
// and hand-written sequences for same-edge collisions and async reset.
// ---------------------------------------------------------------------------
module tb_ps2_keyb_fifo;

    localparam int DL2   = 2;
    localparam int DEPTH = 4;

`ifdef PS2_KEYB_FIFO_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_ = 1'b0;
    logic [7:0] kb_dat_i = 8'h00;
    logic       kb_stb_i = 1'b0;
    logic [1:0] wb_adr_i = 2'd0;
    logic [7:0] wb_dat_i = 8'h00;
    logic [7:0] wb_dat_o;
    logic       wb_we_i = 1'b0;
    logic       wb_stb_i = 1'b0;
    logic       wb_cyc_i = 1'b0;
    logic       wb_ack_o;
    logic       irq_o;

    always #5 clk = ~clk;

    ps2_keyb_fifo #(.DEPTH_LOG2(DL2)) dut (
        .wb_clk_i (clk),
        .rst_     (rst_),
        .kb_dat_i (kb_dat_i),
        .kb_stb_i (kb_stb_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_we_i  (wb_we_i),
        .wb_stb_i (wb_stb_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_ack_o (wb_ack_o),
        .irq_o    (irq_o)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: contents as a queue plus the two sticky flags.
    logic [7:0] q[$];
    logic       ovf_m = 1'b0;
    logic       ie_m  = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] status_exp();
        return {ovf_m, (q.size() == DEPTH), (q.size() != 0), (ie_m & IRQ_ON), 4'b0000};
    endfunction

    function automatic logic irq_exp();
        return IRQ_ON & ie_m & (q.size() != 0);
    endfunction

    task automatic m_push(input logic [7:0] b);
        if (q.size() < DEPTH) q.push_back(b);
        else ovf_m = 1'b1;
    endtask

    task automatic m_read(input logic [1:0] adr, output logic [7:0] e);
        case (adr)
            2'd0: begin
                if (q.size() != 0) e = q.pop_front();
                else e = 8'h00;
            end
            2'd1:    e = status_exp();
            2'd2:    e = 8'(q.size());
            default: e = 8'h00;
        endcase
    endtask

    task automatic m_write(input logic [1:0] adr, input logic [7:0] d);
        if (adr == 2'd1) begin
            ie_m = d[0];
            if (d[1]) q.delete();
            if (d[7]) ovf_m = 1'b0;
        end
    endtask

    task automatic check_irq(input string name);
        check(name, {7'b0, irq_o}, {7'b0, irq_exp()});
    endtask

    // One Wishbone transaction, optionally with a keyboard strobe in the
    // request cycle so it lands on the ack edge. Ends one cycle after ack.
    task automatic bus_op(input logic we, input logic [1:0] adr, input logic [7:0] wdat,
                          input logic push, input logic [7:0] pbyte, output logic [7:0] rdat);
        int n;
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = wdat;
        if (push) begin
            kb_stb_i = 1'b1;
            kb_dat_i = pbyte;
        end
        @(posedge clk); #1;
        kb_stb_i = 1'b0;
        n = 0;
        while (!wb_ack_o && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        check("ack_latency", 8'(n), 8'd0);
        rdat = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(posedge clk); #1;
        check("ack_one_cycle", {7'b0, wb_ack_o}, 8'd0);
    endtask

    task automatic do_push(input logic [7:0] b);
        @(posedge clk); #1;
        kb_stb_i = 1'b1; kb_dat_i = b;
        @(posedge clk); #1;
        kb_stb_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_ = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; kb_stb_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", {7'b0, wb_ack_o}, 8'd0);
        check("rst_dat", wb_dat_o, 8'h00);
        check("rst_irq", {7'b0, irq_o}, 8'd0);
        #3 rst_ = 1'b1;
        q.delete();
        ovf_m = 1'b0;
        ie_m  = 1'b0;
    endtask

    // Directed vector table
    localparam int OP_PUSH = 0, OP_READ = 1, OP_WRITE = 2;
    typedef struct {
        int         op;
        logic [1:0] adr;
        logic [7:0] dat;
        logic [7:0] exp;
    } vec_t;

    function automatic vec_t mk(input int op, input logic [1:0] adr, input logic [7:0] dat,
                                input logic [7:0] exp);
        vec_t v;
        v.op = op; v.adr = adr; v.dat = dat; v.exp = exp;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd, e, b, d;
        logic [1:0] adr;
        logic       pz;
        int         sel;

        // Reset and register reads
        tbl.push_back(mk(OP_READ,  2'd1, 8'h00, 8'h00));
        tbl.push_back(mk(OP_READ,  2'd2, 8'h00, 8'h00));
        // Order and empty read
        tbl.push_back(mk(OP_PUSH,  2'd0, 8'h1C, 8'h00));
        tbl.push_back(mk(OP_PUSH,  2'd0, 8'h32, 8'h00));
        tbl.push_back(mk(OP_PUSH,  2'd0, 8'hF0, 8'h00));
        tbl.push_back(mk(OP_READ,  2'd2, 8'h00, 8'h03));
        tbl.push_back(mk(OP_READ,  2'd0, 8'h00, 8'h1C));
        tbl.push_back(mk(OP_READ,  2'd0, 8'h00, 8'h32));
        tbl.push_back(mk(OP_READ,  2'd0, 8'h00, 8'hF0));
        tbl.push_back(mk(OP_READ,  2'd0, 8'h00, 8'h00));
        tbl.push_back(mk(OP_READ,  2'd2, 8'h00, 8'h00));
        // Fill and overflow
        tbl.push_back(mk(OP_PUSH,  2'd0, 8'h10, 8'h00));
        tbl.push_back(mk(OP_PUSH,  2'd0, 8'h11, 8'h00));
        tbl.push_back(mk(OP_PUSH,  2'd0, 8'h12, 8'h00));
        tbl.push_back(mk(OP_PUSH,  2'd0, 8'h13, 8'h00));
        tbl.push_back(mk(OP_PUSH,  2'd0, 8'h14, 8'h00));
        tbl.push_back(mk(OP_READ,  2'd1, 8'h00, 8'hE0));
        tbl.push_back(mk(OP_READ,  2'd2, 8'h00, 8'h04));
        tbl.push_back(mk(OP_READ,  2'd0, 8'h00, 8'h10));
        tbl.push_back(mk(OP_READ,  2'd0, 8'h00, 8'h11));
        tbl.push_back(mk(OP_READ,  2'd0, 8'h00, 8'h12));
        tbl.push_back(mk(OP_READ,  2'd0, 8'h00, 8'h13));
        tbl.push_back(mk(OP_READ,  2'd1, 8'h00, 8'h80));
        tbl.push_back(mk(OP_WRITE, 2'd1, 8'h80, 8'h00));
        tbl.push_back(mk(OP_READ,  2'd1, 8'h00, 8'h00));
        // Ignored writes and reserved address
        tbl.push_back(mk(OP_WRITE, 2'd0, 8'hAB, 8'h00));
        tbl.push_back(mk(OP_READ,  2'd2, 8'h00, 8'h00));
        tbl.push_back(mk(OP_READ,  2'd3, 8'h00, 8'h00));

        do_reset();
        check_irq("irq_after_reset");

        for (int i = 0; i < tbl.size(); i++) begin
            case (tbl[i].op)
                OP_PUSH: begin
                    do_push(tbl[i].dat);
                    m_push(tbl[i].dat);
                end
                OP_READ: begin
                    bus_op(1'b0, tbl[i].adr, 8'h00, 1'b0, 8'h00, rd);
                    m_read(tbl[i].adr, e);
                    check($sformatf("vec%0d_read_a%0d", i, tbl[i].adr), rd, tbl[i].exp);
                end
                default: begin
                    bus_op(1'b1, tbl[i].adr, tbl[i].dat, 1'b0, 8'h00, rd);
                    m_write(tbl[i].adr, tbl[i].dat);
                end
            endcase
            check_irq($sformatf("vec%0d_irq", i));
        end

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 99));
            b = 8'($urandom);
            if (sel < 35) begin
                do_push(b);
                m_push(b);
            end else if (sel < 85) begin
                if (sel < 65) adr = 2'd0;
                else if (sel < 73) adr = 2'd1;
                else if (sel < 80) adr = 2'd2;
                else adr = 2'd3;
                pz = ($urandom_range(0, 2) == 0);
                bus_op(1'b0, adr, 8'h00, pz, b, rd);
                m_read(adr, e);
                if (pz) m_push(b);
                check($sformatf("rnd%0d_read_a%0d", i, adr), rd, e);
            end else begin
                adr = (sel < 95) ? 2'd1 : 2'($urandom_range(0, 3));
                d = 8'($urandom);
                if ($urandom_range(0, 3) != 0) d[1] = 1'b0;
                bus_op(1'b1, adr, d, 1'b0, 8'h00, rd);
                m_write(adr, d);
            end
            check_irq($sformatf("rnd%0d_irq", i));
        end

        // Simultaneous push and pop on a full FIFO
        do_reset();
        for (int k = 0; k < 4; k++) begin
            do_push(8'hA0 + 8'(k));
            m_push(8'hA0 + 8'(k));
        end
        bus_op(1'b0, 2'd0, 8'h00, 1'b1, 8'h55, rd);
        m_read(2'd0, e);
        m_push(8'h55);
        check("pp_full_head", rd, 8'hA0);
        bus_op(1'b0, 2'd2, 8'h00, 1'b0, 8'h00, rd);
        check("pp_full_count", rd, 8'h04);
        bus_op(1'b0, 2'd1, 8'h00, 1'b0, 8'h00, rd);
        check("pp_full_status", rd, 8'h60);
        for (int k = 0; k < 4; k++) begin
            bus_op(1'b0, 2'd0, 8'h00, 1'b0, 8'h00, rd);
            m_read(2'd0, e);
            check($sformatf("pp_drain%0d", k), rd, (k == 3) ? 8'h55 : 8'hA1 + 8'(k));
        end

        // Interrupt timing
        do_reset();
        bus_op(1'b1, 2'd1, 8'h01, 1'b0, 8'h00, rd);
        m_write(2'd1, 8'h01);
        check_irq("irq_ie_empty");
        @(posedge clk); #1;
        kb_stb_i = 1'b1; kb_dat_i = 8'h2A;
        @(posedge clk); #1;
        kb_stb_i = 1'b0;
        m_push(8'h2A);
        check("irq_not_early", {7'b0, irq_o}, 8'd0);
        @(posedge clk); #1;
        check("irq_rise", {7'b0, irq_o}, {7'b0, IRQ_ON});
        bus_op(1'b0, 2'd0, 8'h00, 1'b0, 8'h00, rd);
        m_read(2'd0, e);
        check("irq_data", rd, 8'h2A);
        check("irq_fall", {7'b0, irq_o}, 8'd0);
        bus_op(1'b1, 2'd1, 8'h00, 1'b0, 8'h00, rd);
        m_write(2'd1, 8'h00);
        do_push(8'h3B);
        m_push(8'h3B);
        check_irq("irq_ie_off_data");
        bus_op(1'b1, 2'd1, 8'h01, 1'b0, 8'h00, rd);
        m_write(2'd1, 8'h01);
        check("irq_ie_write_data", {7'b0, irq_o}, {7'b0, IRQ_ON});
        bus_op(1'b0, 2'd1, 8'h00, 1'b0, 8'h00, rd);
        check("irq_status_ie", rd, IRQ_ON ? 8'h30 : 8'h20);
        bus_op(1'b1, 2'd1, 8'h03, 1'b0, 8'h00, rd);
        m_write(2'd1, 8'h03);
        check("irq_after_flush", {7'b0, irq_o}, 8'd0);

        // Flush wins over a same-edge push
        do_reset();
        do_push(8'h01); m_push(8'h01);
        do_push(8'h02); m_push(8'h02);
        bus_op(1'b1, 2'd1, 8'h02, 1'b1, 8'h77, rd);
        m_write(2'd1, 8'h02);
        bus_op(1'b0, 2'd2, 8'h00, 1'b0, 8'h00, rd);
        check("flush_count", rd, 8'h00);
        bus_op(1'b0, 2'd0, 8'h00, 1'b0, 8'h00, rd);
        check("flush_data", rd, 8'h00);

        // Clear-ovf collides with an overflow event: ovf stays set
        do_reset();
        for (int k = 0; k < 4; k++) begin
            do_push(8'hC0 + 8'(k));
            m_push(8'hC0 + 8'(k));
        end
        bus_op(1'b1, 2'd1, 8'h80, 1'b1, 8'h99, rd);
        m_write(2'd1, 8'h80);
        m_push(8'h99);
        bus_op(1'b0, 2'd1, 8'h00, 1'b0, 8'h00, rd);
        check("clrovf_collide_status", rd, 8'hE0);

        // Async reset with a read outstanding
        do_reset();
        for (int k = 0; k < 3; k++) begin
            do_push(8'h40 + 8'(k));
            m_push(8'h40 + 8'(k));
        end
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 2'd0;
        #2 rst_ = 1'b0;
        @(posedge clk); #1;
        check("arst_no_ack0", {7'b0, wb_ack_o}, 8'd0);
        check("arst_dat", wb_dat_o, 8'h00);
        @(posedge clk); #1;
        check("arst_no_ack1", {7'b0, wb_ack_o}, 8'd0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        #3 rst_ = 1'b1;
        q.delete(); ovf_m = 1'b0; ie_m = 1'b0;
        bus_op(1'b0, 2'd2, 8'h00, 1'b0, 8'h00, rd);
        check("arst_count", rd, 8'h00);
        bus_op(1'b0, 2'd1, 8'h00, 1'b0, 8'h00, rd);
        check("arst_status", rd, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_keyb_fifo.md
# ps2_keyb_fifo

Buffers the scan-code bytes produced by the PS/2 keyboard controller and exposes them to the CPU as a Wishbone slave with status, control and interrupt. Sits directly downstream of `ps2_keyb`: that block's byte output and one-cycle strobe feed this block's push port. The CPU drains codes at its own pace, and no key event is lost while the FIFO has room.

## Interface
Parameters:
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 bytes. Legal range is 1..7.

Ports:
- `wb_clk_i`  in  1  system clock. Single clock domain.
- `rst_`  in  1  asynchronous, active-low reset.
- `kb_dat_i`  in  8  scan-code byte from the keyboard controller.
- `kb_stb_i`  in  1  one-cycle strobe; `kb_dat_i` is valid while it is high.
- `wb_adr_i`  in  2  register select.
- `wb_dat_i`  in  8  write data.
- `wb_dat_o`  out  8  read data, registered.
- `wb_we_i`  in  1  write enable.
- `wb_stb_i`  in  1  strobe.
- `wb_cyc_i`  in  1  cycle.
- `wb_ack_o`  out  1  acknowledge, registered.
- `irq_o`  out  1  interrupt, level, active-high, registered.

## Operation
Register map (`wb_adr_i`):
- **0 DATA (R):**
  - Returns the head byte and pops it.
  - If the FIFO is empty, returns 0x00 and does not pop.
  - Writes are acked and ignored.
- **1 STATUS (R):** `{ovf, full, nempty, ie, 4'b0}`.
- **1 CTRL (W):**
  - bit0 = `ie`, interrupt enable.
  - bit1 = flush (self-clearing). Sets rd_ptr = wr_ptr and count = 0.
  - bit7 = write 1 to clear `ovf`.
- **2 COUNT (R):** count, zero-extended to 8 bits. Width of count is DEPTH_LOG2+1.
- **3:** reads 0x00; writes are ignored.

FIFO storage:
- Pointers are DEPTH_LOG2 bits and wrap naturally modulo depth.
- count range is 0..2^DEPTH_LOG2.
- full = (count == depth); nempty = (count != 0).

Push and pop rules:
- **Push:** happens when `kb_stb_i` is high and (not full, or a pop occurs in the same cycle). The byte is written at wr_ptr, wr_ptr increments and count increments.
- **Overflow:** `kb_stb_i` while full with no pop in the same cycle drops the byte and sets sticky `ovf`. The FIFO contents are unchanged.
- **Pop:** occurs on the clock edge that registers `wb_ack_o` for a DATA read with nempty true. `wb_dat_o` captures mem[rd_ptr] on that same edge, then rd_ptr increments.
- **Push and pop in the same cycle:** both take effect and count is unchanged. On an empty FIFO a pop cannot occur, so the read returns 0x00 and the push still lands.
- **Flush vs push in the same cycle:** flush wins and the pushed byte is discarded. `ovf` is unaffected by flush.
- **Clear-ovf vs overflow event in the same cycle:** `ovf` ends up set.

Interrupt:
- `irq_o` <= `ie` & nempty, evaluated after the current cycle's push, pop or flush.

Reset (`rst_` low, asynchronous):
- Pointers, count, `ovf` and `ie` go to 0.
- `wb_dat_o` = 0x00, `wb_ack_o` = 0, `irq_o` = 0.
- FIFO memory contents are don't-care.
- A reset in the middle of a transaction aborts it; no ack is issued.

## Timing
Wishbone handshake:
- `wb_ack_o` <= `wb_cyc_i` & `wb_stb_i` & !`wb_ack_o`.
- Ack rises on the edge after the request is first sampled and stays high exactly one cycle.
- The master holds `stb` until it sees ack.
- Back-to-back requests are serviced every second cycle.

Data and side effects:
- `wb_dat_o` is valid while `wb_ack_o` is high and holds its value until the next read ack.
- Write side effects (`ie`, flush, clear-ovf) take place on the ack edge.

Latencies:
- A byte strobed at edge N is visible to any read acked at edge N+1 or later.
- `irq_o` rises at edge N+1 after a push at edge N into an empty FIFO with `ie` set.
- `irq_o` falls on the edge after the pop that empties the FIFO.
- A write of `ie` = 1 acked at edge N with data present gives `irq_o` high at N+1.

## Configuration
Macro `PS2_KEYB_FIFO_IRQ_EN`:
- **Defined:** `ie` and `irq_o` behave as specified above.
- **Undefined:** `irq_o` is tied 0, the `ie` flop is removed and the STATUS `ie` bit reads 0. Everything else is unchanged.

## Test plan
- **Reset:** hold `rst_` low, release, read STATUS and COUNT → 0x00 and 0x00. `irq_o` = 0, `wb_ack_o` pulses exactly one cycle per read.
- **Order and empty read:** push 0x1C, 0x32, 0xF0 → COUNT = 3. DATA reads return 0x1C, 0x32, 0xF0 in order. A fourth DATA read returns 0x00, COUNT stays 0.
- **Fill and overflow:** with DEPTH_LOG2 = 2, push 0x10..0x14 → STATUS = 0xE0 (ovf, full, nempty). Reads return 0x10..0x13; 0x14 is lost. Writing 0x80 to CTRL → STATUS = 0x00 once drained.
- **Simultaneous push and pop on full FIFO:** strobe 0x55 on the exact ack edge of a DATA read → read returns the old head, COUNT stays 4, `ovf` stays 0, and 0x55 is read last.
- **Interrupt (macro defined):** write CTRL = 0x01, push 0x2A → `irq_o` high the next cycle. Reading DATA gives 0x2A and `irq_o` low the cycle after. With the macro undefined, `irq_o` stays 0 throughout.
- **Flush collision and async reset:** CTRL write 0x02 acked on the same edge as a push → COUNT = 0. Separately, assert `rst_` with 3 bytes queued while a read is outstanding → no ack, COUNT = 0 after release.
